// File: rtl/wb_result_unit_if.sv
// rtl/wb_result_unit_if.sv - MEM-to-WB bundle for the writeback result unit
// master: MEM-stage side (drives *_M, stall, flush; observes WB results)
// slave : wb_result_unit (consumes *_M, stall, flush; drives WB results)
interface wb_result_unit_if #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 2,
    parameter int CNT_W = 32
);
    logic             valid_M;
    logic             stall;
    logic             flush;
    logic [SEL_W-1:0] WBSel_M;
    logic             RegWEn_M;
    logic [4:0]       rd_M;
    logic [2:0]       funct3_M;
    logic [1:0]       addr_lo_M;
    logic [XLEN-1:0]  Alu_out_M;
    logic [XLEN-1:0]  PCPlus4_M;
    logic [XLEN-1:0]  Aux_M;
    logic [XLEN-1:0]  Data_Load_M;

    logic             valid_WB;
    logic             RegWEn_WB;
    logic [4:0]       rd_WB;
    logic [XLEN-1:0]  dataW;
    logic             misalign_WB;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output valid_M, stall, flush, WBSel_M, RegWEn_M, rd_M, funct3_M,
               addr_lo_M, Alu_out_M, PCPlus4_M, Aux_M, Data_Load_M,
        input  valid_WB, RegWEn_WB, rd_WB, dataW, misalign_WB, retire_cnt
    );

    modport slave (
        input  valid_M, stall, flush, WBSel_M, RegWEn_M, rd_M, funct3_M,
               addr_lo_M, Alu_out_M, PCPlus4_M, Aux_M, Data_Load_M,
        output valid_WB, RegWEn_WB, rd_WB, dataW, misalign_WB, retire_cnt
    );
endinterface

// File: rtl/wb_result_unit.sv
// rtl/wb_result_unit.sv - MEM/WB register, load extraction, result select and retire counter
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - wb_result_unit_if.slave: MEM-stage inputs (valid_M, stall, flush,
//           WBSel_M, RegWEn_M, rd_M, funct3_M, addr_lo_M, Alu_out_M, PCPlus4_M,
//           Aux_M, Data_Load_M) and WB outputs (valid_WB, RegWEn_WB, rd_WB,
//           dataW, misalign_WB, retire_cnt). All outputs come from the WB
//           register only.
module wb_result_unit #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_result_unit_if.slave   bus
);

    logic             v_q;
    logic [SEL_W-1:0] sel_q;
    logic             we_q;
    logic [4:0]       rd_q;
    logic [2:0]       f3_q;
    logic [1:0]       alo_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  pc4_q;
    logic [XLEN-1:0]  aux_q;
    logic [XLEN-1:0]  ld_q;
    logic [CNT_W-1:0] cnt_q;

    logic             misalign;
    logic             retire;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [XLEN-1:0]  load_res;
    logic [XLEN-1:0]  data_w;

    // The WB instruction leaves the stage on any edge that is not a pure
    // stall; a flush overrides stall, so the departing instruction counts.
    assign retire = v_q & ~misalign & (~bus.stall | bus.flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= 1'b0;
            sel_q <= '0;
            we_q  <= 1'b0;
            rd_q  <= '0;
            f3_q  <= '0;
            alo_q <= '0;
            alu_q <= '0;
            pc4_q <= '0;
            aux_q <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (bus.flush) begin
                v_q   <= 1'b0;
                sel_q <= '0;
                we_q  <= 1'b0;
                rd_q  <= '0;
                f3_q  <= '0;
                alo_q <= '0;
                alu_q <= '0;
                pc4_q <= '0;
                aux_q <= '0;
                ld_q  <= '0;
            end else if (!bus.stall) begin
                v_q   <= bus.valid_M;
                sel_q <= bus.WBSel_M;
                we_q  <= bus.RegWEn_M;
                rd_q  <= bus.rd_M;
                f3_q  <= bus.funct3_M;
                alo_q <= bus.addr_lo_M;
                alu_q <= bus.Alu_out_M;
                pc4_q <= bus.PCPlus4_M;
                aux_q <= bus.Aux_M;
                ld_q  <= bus.Data_Load_M;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Little-endian lane selection; halfwords use addr_lo[1] only, so an
    // odd halfword address still yields a lane but is flagged misaligned.
    always_comb begin
        byte_v   = ld_q[{alo_q, 3'b000} +: 8];
        half_v   = ld_q[{alo_q[1], 4'b0000} +: 16];
        load_res = '0;
        case (f3_q)
            3'b000:  load_res = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b001:  load_res = {{(XLEN-16){half_v[15]}}, half_v};
            3'b010:  load_res = ld_q;
            3'b100:  load_res = {{(XLEN-8){1'b0}}, byte_v};
            3'b101:  load_res = {{(XLEN-16){1'b0}}, half_v};
            default: load_res = '0;
        endcase
    end

    assign misalign = v_q & (sel_q == '0) &
                      (((f3_q[1:0] == 2'b01) & alo_q[0]) |
                       ((f3_q == 3'b010) & (alo_q != 2'b00)));

    // Sources beyond NSRC read as zero so a narrower build never leaks
    // a stale aux/PC value.
    always_comb begin
        data_w = '0;
        case (sel_q)
            SEL_W'(0): data_w = load_res;
            SEL_W'(1): data_w = alu_q;
            SEL_W'(2): data_w = (NSRC > 2) ? pc4_q : '0;
            SEL_W'(3): data_w = (NSRC > 3) ? aux_q : '0;
            default:   data_w = '0;
        endcase
    end

    assign bus.valid_WB    = v_q;
    assign bus.RegWEn_WB   = v_q & we_q & (rd_q != 5'd0) & ~misalign;
    assign bus.rd_WB       = rd_q;
    assign bus.dataW       = data_w;
    assign bus.misalign_WB = misalign;
    assign bus.retire_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_result_unit.sv
// tb/tb_wb_result_unit.sv - self-checking bench for wb_result_unit
module tb_wb_result_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_M = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  sel = '0;
    logic        regwen = 1'b0;
    logic [4:0]  rd = '0;
    logic [2:0]  f3 = '0;
    logic [1:0]  alo = '0;
    logic [31:0] alu = '0, pc4 = '0, aux = '0, ld = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_result_unit_if #(.XLEN(32), .SEL_W(2), .CNT_W(32)) i4 ();
    wb_result_unit_if #(.XLEN(32), .SEL_W(2), .CNT_W(32)) i3 ();
    wb_result_unit_if #(.XLEN(32), .SEL_W(2), .CNT_W(4))  iw ();

    assign {i4.valid_M, i4.stall, i4.flush, i4.WBSel_M, i4.RegWEn_M, i4.rd_M, i4.funct3_M,
            i4.addr_lo_M, i4.Alu_out_M, i4.PCPlus4_M, i4.Aux_M, i4.Data_Load_M} =
           {valid_M, stall, flush, sel, regwen, rd, f3, alo, alu, pc4, aux, ld};
    assign {i3.valid_M, i3.stall, i3.flush, i3.WBSel_M, i3.RegWEn_M, i3.rd_M, i3.funct3_M,
            i3.addr_lo_M, i3.Alu_out_M, i3.PCPlus4_M, i3.Aux_M, i3.Data_Load_M} =
           {valid_M, stall, flush, sel, regwen, rd, f3, alo, alu, pc4, aux, ld};
    assign {iw.valid_M, iw.stall, iw.flush, iw.WBSel_M, iw.RegWEn_M, iw.rd_M, iw.funct3_M,
            iw.addr_lo_M, iw.Alu_out_M, iw.PCPlus4_M, iw.Aux_M, iw.Data_Load_M} =
           {valid_M, stall, flush, sel, regwen, rd, f3, alo, alu, pc4, aux, ld};

    wb_result_unit #(.XLEN(32), .NSRC(4), .SEL_W(2), .CNT_W(32)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    wb_result_unit #(.XLEN(32), .NSRC(3), .SEL_W(2), .CNT_W(32)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(i3));
    wb_result_unit #(.XLEN(32), .NSRC(4), .SEL_W(2), .CNT_W(4))  u_dutw (.clk(clk), .rst_n(rst_n), .bus(iw));

    // Reference model: the instruction currently held in WB plus a retire total.
    typedef struct packed {
        logic        v;
        logic [1:0]  sel;
        logic        we;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] alu, pc4, aux, ld;
    } wb_t;

    wb_t         m;
    int unsigned mcnt;

    function automatic logic [31:0] m_load(input wb_t w);
        logic [31:0] b, h;
        b = (w.ld >> (8 * w.alo)) & 32'hFF;
        h = (w.ld >> (16 * w.alo[1])) & 32'hFFFF;
        case (w.f3)
            3'd0:    return (b >= 128)   ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd2:    return w.ld;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_mis(input wb_t w);
        return w.v && w.sel == 0 &&
               (((w.f3 == 1 || w.f3 == 5) && w.alo % 2 == 1) || (w.f3 == 2 && w.alo != 0));
    endfunction

    function automatic logic [31:0] m_data(input wb_t w, input int nsrc);
        if (w.sel >= nsrc) return 32'd0;
        case (w.sel)
            2'd0:    return m_load(w);
            2'd1:    return w.alu;
            2'd2:    return w.pc4;
            default: return w.aux;
        endcase
    endfunction

    function automatic logic m_we(input wb_t w);
        return w.v && w.we && w.rd != 0 && !m_mis(w);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("valid_WB",    64'(i4.valid_WB),    64'(m.v));
        chk("RegWEn_WB",   64'(i4.RegWEn_WB),   64'(m_we(m)));
        chk("rd_WB",       64'(i4.rd_WB),       64'(m.rd));
        chk("dataW",       64'(i4.dataW),       64'(m_data(m, 4)));
        chk("misalign_WB", 64'(i4.misalign_WB), 64'(m_mis(m)));
        chk("retire_cnt",  64'(i4.retire_cnt),  64'(mcnt));
        chk("dataW_nsrc3", 64'(i3.dataW),       64'(m_data(m, 3)));
        chk("retire_cnt4", 64'(iw.retire_cnt),  64'(mcnt % 16));
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        if (m.v && !m_mis(m) && (!stall || flush)) mcnt++;
        if (flush)       m = '0;
        else if (!stall) m = {valid_M, sel, regwen, rd, f3, alo, alu, pc4, aux, ld};
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(i4.valid_WB), 64'd0);
        chk({tag, "_we"},    64'(i4.RegWEn_WB), 64'd0);
        chk({tag, "_rd"},    64'(i4.rd_WB), 64'd0);
        chk({tag, "_data"},  64'(i4.dataW), 64'd0);
        chk({tag, "_mis"},   64'(i4.misalign_WB), 64'd0);
        chk({tag, "_cnt"},   64'(i4.retire_cnt), 64'd0);
        chk({tag, "_cntw"},  64'(iw.retire_cnt), 64'd0);
    endtask

    // Async reset applied between edges; held across one edge with valid_M high.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m = '0;
        mcnt = 0;
        check_zero("rst_now");
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic set_op(input logic [1:0] s, input logic [4:0] r, input logic [2:0] f,
                          input logic [1:0] a);
        valid_M = 1'b1; regwen = 1'b1; sel = s; rd = r; f3 = f; alo = a;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_we;
    } vec_t;

    vec_t tbl[7];
    int unsigned c0;

    initial begin
        tbl[0] = '{3'b000, 2'd3, 5'd1, 32'hFFFFFF80, 1'b0, 1'b1};
        tbl[1] = '{3'b100, 2'd1, 5'd2, 32'h0000007F, 1'b0, 1'b1};
        tbl[2] = '{3'b001, 2'd2, 5'd3, 32'hFFFF80FF, 1'b0, 1'b1};
        tbl[3] = '{3'b101, 2'd0, 5'd4, 32'h00007F01, 1'b0, 1'b1};
        tbl[4] = '{3'b010, 2'd0, 5'd6, 32'h80FF7F01, 1'b0, 1'b1};
        tbl[5] = '{3'b010, 2'd2, 5'd7, 32'h80FF7F01, 1'b1, 1'b0};
        tbl[6] = '{3'b001, 2'd1, 5'd7, 32'h00007F01, 1'b1, 1'b0};

        m = '0;
        mcnt = 0;
        @(posedge clk);
        do_reset();

        // A little traffic, then reset mid-stream with a valid instruction in flight.
        set_op(2'd1, 5'd9, 3'd0, 2'd0);
        alu = 32'h11110000;
        cycle();
        cycle();
        do_reset();

        alu = 32'h12345678;
        set_op(2'd1, 5'd5, 3'd0, 2'd0);
        cycle();
        chk("alu_data", 64'(i4.dataW), 64'h12345678);
        chk("alu_we",   64'(i4.RegWEn_WB), 64'd1);
        chk("alu_rd",   64'(i4.rd_WB), 64'd5);
        chk("alu_cnt0", 64'(i4.retire_cnt), 64'd0);
        valid_M = 1'b0;
        cycle();
        chk("alu_cnt1", 64'(i4.retire_cnt), 64'd1);

        // Load extraction and misalignment vectors.
        ld = 32'h80FF7F01;
        for (int i = 0; i < 7; i++) begin
            set_op(2'd0, tbl[i].rd, tbl[i].f3, tbl[i].alo);
            c0 = mcnt;
            cycle();
            chk($sformatf("ld%0d_data", i), 64'(i4.dataW), 64'(tbl[i].exp_data));
            chk($sformatf("ld%0d_mis", i),  64'(i4.misalign_WB), 64'(tbl[i].exp_mis));
            chk($sformatf("ld%0d_we", i),   64'(i4.RegWEn_WB), 64'(tbl[i].exp_we));
            valid_M = 1'b0;
            cycle();
            chk($sformatf("ld%0d_cnt", i), 64'(i4.retire_cnt), 64'(c0 + (tbl[i].exp_mis ? 0 : 1)));
        end

        // Source select and write gating.
        pc4 = 32'h00000104;
        set_op(2'd2, 5'd8, 3'd0, 2'd0);
        cycle();
        chk("pc4_data", 64'(i4.dataW), 64'h104);
        aux = 32'hABCD0000;
        set_op(2'd3, 5'd8, 3'd0, 2'd0);
        cycle();
        chk("aux_data4", 64'(i4.dataW), 64'hABCD0000);
        chk("aux_data3", 64'(i3.dataW), 64'h0);
        set_op(2'd1, 5'd0, 3'd0, 2'd0);
        cycle();
        chk("rd0_we", 64'(i4.RegWEn_WB), 64'd0);

        // Stall holds everything; flush+stall drops in a bubble and retires the holder.
        alu = 32'h0BADF00D;
        set_op(2'd1, 5'd9, 3'd0, 2'd0);
        cycle();
        c0 = mcnt;
        stall = 1'b1;
        alu = 32'hDEADBEEF;
        rd = 5'd12;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_data", 64'(i4.dataW), 64'h0BADF00D);
            chk("stall_rd",   64'(i4.rd_WB), 64'd9);
            chk("stall_cnt",  64'(i4.retire_cnt), 64'(c0));
        end
        flush = 1'b1;
        cycle();
        chk("flush_valid", 64'(i4.valid_WB), 64'd0);
        chk("flush_we",    64'(i4.RegWEn_WB), 64'd0);
        chk("flush_data",  64'(i4.dataW), 64'd0);
        chk("flush_cnt",   64'(i4.retire_cnt), 64'(c0 + 1));
        stall = 1'b0;
        flush = 1'b0;

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            valid_M = 1'($urandom_range(0, 3) != 0);
            stall   = 1'($urandom_range(0, 3) == 0);
            flush   = 1'($urandom_range(0, 7) == 0);
            sel     = 2'($urandom_range(0, 3));
            regwen  = 1'($urandom_range(0, 1));
            rd      = 5'($urandom_range(0, 31));
            f3      = 3'($urandom_range(0, 7));
            alo     = 2'($urandom_range(0, 3));
            alu     = $urandom;
            pc4     = $urandom;
            aux     = $urandom;
            ld      = $urandom;
            cycle();
        end
        stall = 1'b0;
        flush = 1'b0;

        // Counter wrap on the 4-bit build: 17 retirements end at 1.
        do_reset();
        set_op(2'd1, 5'd3, 3'd0, 2'd0);
        for (int k = 0; k < 17; k++) begin
            alu = 32'(k);
            cycle();
        end
        valid_M = 1'b0;
        cycle();
        chk("wrap_cnt4",  64'(iw.retire_cnt), 64'd1);
        chk("wrap_cnt32", 64'(i4.retire_cnt), 64'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_result_unit.md
Name: wb_result_unit

Overview:
- Parametrised writeback-stage successor to the 3-way writeback result mux. Combines the MEM/WB pipeline register (with stall and flush), load byte/halfword extraction with sign/zero extension, an N-source result select, write-enable gating, misaligned-load detection and a retired-instruction counter.
- Sits between the data-memory stage and the register-file write port. Its outputs drive the register-file write port and the forwarding paths directly.

Parameters:
- XLEN, 32, datapath width (bits) of all data ports.
- NSRC, 4, number of result sources used, 2..4. Sources: 0 = load, 1 = ALU, 2 = PC+4, 3 = aux (LUI imm / CSR read).
- SEL_W, 2, width of the writeback select field; must satisfy 2^SEL_W >= NSRC.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_M  in  1  MEM stage holds a real instruction.
- stall  in  1  hold the WB register.
- flush  in  1  load a bubble into the WB register.
- WBSel_M  in  SEL_W  result source select.
- RegWEn_M  in  1  instruction writes rd.
- rd_M  in  5  destination register.
- funct3_M  in  3  load type.
- addr_lo_M  in  2  load address bits [1:0].
- Alu_out_M  in  XLEN  ALU result.
- PCPlus4_M  in  XLEN  next-instruction address.
- Aux_M  in  XLEN  aux result.
- Data_Load_M  in  XLEN  raw word read from data memory.
- valid_WB  out  1  WB holds a real instruction.
- RegWEn_WB  out  1  gated register-file write enable.
- rd_WB  out  5  destination register.
- dataW  out  XLEN  write-back data.
- misalign_WB  out  1  WB instruction is a misaligned load.
- retire_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0): all WB registers and retire_cnt clear to 0. Outputs are then valid_WB=0, RegWEn_WB=0, rd_WB=0, dataW=0, misalign_WB=0, retire_cnt=0. Reset mid-stall or mid-flush takes immediate effect.
- Pipeline register, on each rising edge:
  - flush=1: valid=0 and all other fields are don't-care, but are cleared to 0. Flush wins over stall.
  - else stall=1: all fields hold.
  - else: capture all *_M inputs; the valid bit takes valid_M.
- Latency: one cycle from the MEM inputs to the WB outputs. All outputs are combinational from the WB register only; there is no input-to-output combinational path.
- Load extraction, using the registered funct3 and addr_lo:
  - 000 LB: byte addr_lo, sign-extended.
  - 001 LH: halfword addr_lo[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte addr_lo, zero-extended.
  - 101 LHU: halfword addr_lo[1], zero-extended.
  - Any other funct3: load result is 0.
  - Byte n occupies bits [8n+7:8n]; little-endian.
- misalign_WB = valid & (WBSel==0) & ((LH/LHU & addr_lo[0]) | (LW & addr_lo!=0)).
- dataW by registered WBSel:
  - 0: load result.
  - 1: ALU result.
  - 2: PC+4.
  - 3: aux.
  - Any select value >= NSRC: 0. This includes 3 when NSRC=3.
- RegWEn_WB = valid & RegWEn & (rd!=0) & !misalign_WB.
- During stall the same write is repeated each cycle; this is harmless.
- retire_cnt:
  - Increments by 1 on an edge where valid_WB=1 & misalign_WB=0 & (stall=0 | flush=1), i.e. the WB instruction leaves the stage non-trapped.
  - Wraps from 2^CNT_W-1 to 0.
  - A misaligned load does not count.
- Simultaneous flush and stall: bubble inserted; the departing valid instruction is counted.

Test Plan:
- Reset: assert rst_n=0 mid-stream with valid_M=1 -> all outputs 0 immediately. Deassert, send ALU op: Alu_out_M=0x12345678, WBSel=1, rd=5 -> next cycle dataW=0x12345678, RegWEn_WB=1, rd_WB=5, and retire_cnt goes 0→1 on the following edge.
- Loads, Data_Load_M=0x80FF7F01:
  - LB addr 3 -> 0xFFFFFF80.
  - LBU addr 1 -> 0x0000007F.
  - LH addr 2 -> 0xFFFF80FF.
  - LHU addr 0 -> 0x00007F01.
  - LW addr 0 -> 0x80FF7F01.
- Misaligned: LW addr 2, rd=7 -> misalign_WB=1, RegWEn_WB=0, retire_cnt unchanged. LH addr 1 -> same response.
- Select and gating:
  - WBSel=2, PCPlus4_M=0x00000104 -> dataW=0x104.
  - WBSel=3, Aux_M=0xABCD0000 -> dataW=0xABCD0000 with NSRC=4, and 0 with NSRC=3.
  - rd=0 with RegWEn=1 -> RegWEn_WB=0.
- Stall/flush:
  - stall=1 for 3 cycles -> WB outputs frozen and retire_cnt constant.
  - flush=1 together with stall=1 -> next cycle valid_WB=0, RegWEn_WB=0, dataW=0, and retire_cnt +1 for the departing instruction.
- Wrap: CNT_W=4, retire 17 back-to-back valid ALU ops -> retire_cnt ends at 1.
